// File: rtl/ctrl_subrutina.sv
// ctrl_subrutina: call/return sequencer driving the hardware stack.
// Define CTRL_SUBR_PROF_EN for depth tracking, overflow/underflow flags and ERROR.
module ctrl_subrutina #(
    parameter int WIDTH     = 10,
    parameter int PROF_MAX  = 16,
    parameter int PROF_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 call,
    input  logic                 ret,
    input  logic [WIDTH-1:0]     pc_ret,
    input  logic [WIDTH-1:0]     dest_call,
    input  logic [WIDTH-1:0]     salida_pila,
    output logic                 weSP,
    output logic                 push,
    output logic                 pop,
    output logic [WIDTH-1:0]     dato_pila,
    output logic [WIDTH-1:0]     nuevo_pc,
    output logic                 pc_valido,
    output logic                 stall,
    output logic [PROF_BITS-1:0] profundidad,
    output logic                 err_desbordamiento,
    output logic                 err_vacia
);

`ifdef CTRL_SUBR_PROF_EN
    typedef enum logic [2:0] {IDLE, PUSH, POP, SALTO, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, PUSH, POP, SALTO} state_t;
`endif

    localparam logic [PROF_BITS-1:0] PROF_LIM = PROF_BITS'(PROF_MAX);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] nuevo_pc_q, nuevo_pc_d;

`ifdef CTRL_SUBR_PROF_EN
    logic [PROF_BITS-1:0] prof_q, prof_d;
    logic                 err_o_q, err_o_d;
    logic                 err_v_q, err_v_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prof_q  <= '0;
            err_o_q <= 1'b0;
            err_v_q <= 1'b0;
        end else begin
            prof_q  <= prof_d;
            err_o_q <= err_o_d;
            err_v_q <= err_v_d;
        end
    end

    assign profundidad        = prof_q;
    assign err_desbordamiento = err_o_q;
    assign err_vacia          = err_v_q;
`else
    logic [PROF_BITS-1:0] unused_prof_lim;

    assign unused_prof_lim    = PROF_LIM;
    assign profundidad        = '0;
    assign err_desbordamiento = 1'b0;
    assign err_vacia          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ret_addr_q <= '0;
            target_q   <= '0;
            nuevo_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_addr_q <= ret_addr_d;
            target_q   <= target_d;
            nuevo_pc_q <= nuevo_pc_d;
        end
    end

    assign dato_pila = ret_addr_q;

    always_comb begin
        state_d    = state_q;
        ret_addr_d = ret_addr_q;
        target_d   = target_q;
        nuevo_pc_d = nuevo_pc_q;
        nuevo_pc   = nuevo_pc_q;
        weSP       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        pc_valido  = 1'b0;
        stall      = 1'b0;
`ifdef CTRL_SUBR_PROF_EN
        prof_d     = prof_q;
        err_o_d    = err_o_q;
        err_v_d    = err_v_q;
`endif
        unique case (state_q)
            IDLE: begin
                // call has priority; a simultaneous ret is dropped
                if (call) begin
`ifdef CTRL_SUBR_PROF_EN
                    if (prof_q == PROF_LIM) begin
                        state_d = ERROR;
                        err_o_d = 1'b1;
                    end else
`endif
                    begin
                        ret_addr_d = pc_ret;
                        target_d   = dest_call;
                        state_d    = PUSH;
                    end
                end else if (ret) begin
`ifdef CTRL_SUBR_PROF_EN
                    if (prof_q == '0) begin
                        state_d = ERROR;
                        err_v_d = 1'b1;
                    end else
`endif
                    begin
                        state_d = POP;
                    end
                end
            end
            PUSH: begin
                push    = 1'b1;
                weSP    = 1'b1;
                stall   = 1'b1;
                state_d = SALTO;
`ifdef CTRL_SUBR_PROF_EN
                prof_d  = prof_q + PROF_BITS'(1);
`endif
            end
            POP: begin
                pop      = 1'b1;
                weSP     = 1'b1;
                stall    = 1'b1;
                target_d = salida_pila;
                state_d  = SALTO;
`ifdef CTRL_SUBR_PROF_EN
                prof_d   = prof_q - PROF_BITS'(1);
`endif
            end
            SALTO: begin
                nuevo_pc   = target_q;
                nuevo_pc_d = target_q;
                pc_valido  = 1'b1;
                stall      = 1'b1;
                state_d    = IDLE;
            end
`ifdef CTRL_SUBR_PROF_EN
            ERROR: begin
                stall = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
